// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for mem_arbiter.
//   last_grant_e  : round-robin pointer state, remembers the most recent grantee
//   misaligned()  : true when a byte address is not word aligned
package mem_arbiter_pkg;

  typedef enum logic {
    LAST_IF = 1'b0,
    LAST_LS = 1'b1
  } last_grant_e;

  function automatic logic misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_defines.sv
// Shared width defaults for the memory arbiter slice.
//   ADDR_WIDTH : default requester / memory byte-address width
//   DATA_WIDTH : default data width
//   ZERO       : width-agnostic zero fill for reset values
`ifndef MEM_ARBITER_DEFINES_SV
`define MEM_ARBITER_DEFINES_SV
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define ZERO '0
`endif

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin selector.
//   req   [1:0] : request vector, bit 0 = fetch, bit 1 = load/store
//   ptr         : requester granted most recently
//   grant [1:0] : one-hot selection (all zero when nothing requests)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  last_grant_e ptr,
  output logic [1:0]  grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      // Conflict: the side not served most recently wins.
      grant = (ptr == LAST_IF) ? 2'b10 : 2'b01;
    end else begin
      // A lone requester wins regardless of the pointer.
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between an instruction
// fetch port and a load/store port.
//   clk_i, rst_i          : clock (rising edge), asynchronous active-low reset
//   if_*                  : fetch request (req/addr) and response (gnt/rvalid/rdata/err)
//   ls_*                  : load/store request (req/we/addr/wdata) and response
//   halt_i                : blocks every new grant while high
//   mem_addr_o/we/wdata   : shared memory request, word aligned
//   mem_rdata_i           : combinational read data for mem_addr_o
//   conflict_cnt_o        : saturating count of cycles with both requests pending
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_err_o,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  last_grant_e           last_q;
  logic [1:0]            sel_p0;
  logic                  gnt_if_p0;
  logic                  gnt_ls_p0;
  logic                  mis_if_p0;
  logic                  mis_ls_p0;
  logic                  conflict_p0;

  logic                  if_rvalid_p1;
  logic                  if_err_p1;
  logic [DATA_WIDTH-1:0] if_rdata_p1;
  logic                  ls_rvalid_p1;
  logic                  ls_err_p1;
  logic [DATA_WIDTH-1:0] ls_rdata_p1;
  logic [CNT_WIDTH-1:0]  conflict_cnt_p1;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- p0: arbitration and memory request (combinational) ----
  rr_arb2 u_rr_arb2 (
    .req   ({ls_req_i, if_req_i}),
    .ptr   (last_q),
    .grant (sel_p0)
  );

  // Reset is folded into the grant so nothing reaches memory while held.
  assign gnt_if_p0   = rst_i & ~halt_i & sel_p0[0];
  assign gnt_ls_p0   = rst_i & ~halt_i & sel_p0[1];
  assign mis_if_p0   = misaligned(if_addr_i[1:0]);
  assign mis_ls_p0   = misaligned(ls_addr_i[1:0]);
  assign conflict_p0 = if_req_i & ls_req_i & ~halt_i;

  assign if_gnt_o = gnt_if_p0;
  assign ls_gnt_o = gnt_ls_p0;

  always_comb begin
    mem_addr_o = `ZERO;
    if (gnt_ls_p0) begin
      mem_addr_o = word_align(ls_addr_i);
    end else if (gnt_if_p0) begin
      mem_addr_o = word_align(if_addr_i);
    end
  end

  // Misaligned stores are granted but never reach memory.
  assign mem_we_o    = gnt_ls_p0 & ls_we_i & ~mis_ls_p0;
  assign mem_wdata_o = ls_wdata_i;

  // Round-robin pointer: moves only when somebody is granted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= LAST_IF;
    end else if (gnt_ls_p0) begin
      last_q <= LAST_LS;
    end else if (gnt_if_p0) begin
      last_q <= LAST_IF;
    end
  end

  // ---- p1: registered responses, one cycle after the grant ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_rvalid_p1    <= `ZERO;
      if_err_p1       <= `ZERO;
      if_rdata_p1     <= `ZERO;
      ls_rvalid_p1    <= `ZERO;
      ls_err_p1       <= `ZERO;
      ls_rdata_p1     <= `ZERO;
      conflict_cnt_p1 <= `ZERO;
    end else begin
      if_rvalid_p1 <= gnt_if_p0;
      if_err_p1    <= gnt_if_p0 & mis_if_p0;
      ls_rvalid_p1 <= gnt_ls_p0;
      ls_err_p1    <= gnt_ls_p0 & mis_ls_p0;
      // Read data is held between responses; error responses carry zero.
      if (gnt_if_p0) begin
        if_rdata_p1 <= mis_if_p0 ? `ZERO : mem_rdata_i;
      end
      if (gnt_ls_p0) begin
        ls_rdata_p1 <= mis_ls_p0 ? `ZERO : mem_rdata_i;
      end
      if (conflict_p0) begin
        conflict_cnt_p1 <= sat_inc(conflict_cnt_p1);
      end
    end
  end

  assign if_rvalid_o    = if_rvalid_p1;
  assign if_err_o       = if_err_p1;
  assign if_rdata_o     = if_rdata_p1;
  assign ls_rvalid_o    = ls_rvalid_p1;
  assign ls_err_o       = ls_err_p1;
  assign ls_rdata_o     = ls_rdata_p1;
  assign conflict_cnt_o = conflict_cnt_p1;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH, default `ADDR_WIDTH, requester address width; DATA_WIDTH, default `DATA_WIDTH, data width; CNT_WIDTH, default 16, conflict counter width.
REQ-002 SHALL provide the following ports:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  instruction-fetch request
- if_addr_i  in  ADDR_WIDTH  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_WIDTH  fetch data
- if_err_o  out  1  fetch response is an error, qualified by if_rvalid_o
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_WIDTH  load/store byte address
- ls_wdata_i  in  DATA_WIDTH  store data
- ls_gnt_o  out  1  load/store accepted
- ls_rvalid_o  out  1  load/store response valid (loads and stores)
- ls_rdata_o  out  DATA_WIDTH  load data
- ls_err_o  out  1  load/store error, qualified by ls_rvalid_o
- halt_i  in  1  suppress all new grants
- mem_addr_o  out  ADDR_WIDTH  shared memory address, word aligned
- mem_we_o  out  1  shared memory write enable
- mem_wdata_o  out  DATA_WIDTH  shared memory write data
- mem_rdata_i  in  DATA_WIDTH  combinational read data for mem_addr_o
- conflict_cnt_o  out  CNT_WIDTH  count of cycles in which both requesters were pending

Function
REQ-003 SHALL grant at most one requester per cycle; grant is combinational: gnt_o = req_i AND selected AND NOT halt_i.
REQ-004 Arbitration SHALL be round-robin on conflict: if both requests are high, grant the requester not granted most recently.
REQ-005 The last-grant pointer SHALL reset to "fetch", so the first conflict after reset grants load/store.
REQ-006 A lone requester SHALL be granted immediately, whatever the pointer value.
REQ-007 In a granted cycle the memory outputs SHALL carry the granted requester's address, with addr[1:0] forced to 0.
- mem_we_o = ls_we_i when load/store is granted, else 0.
- mem_wdata_o = ls_wdata_i.
REQ-008 mem_we_o SHALL be 0 in every cycle without a load/store store grant.
REQ-009 Response latency SHALL be exactly 1 cycle: rvalid_o pulses for one cycle in the cycle after gnt_o.
- rdata_o is mem_rdata_i registered in the grant cycle.
- rdata_o holds its value until the next response.
REQ-010 Back-to-back operation SHALL be supported: a new grant may occur in the same cycle as the previous response, giving full throughput of one access per cycle.
REQ-011 Requesters SHALL hold req_i and all request fields stable until gnt_o; the arbiter SHALL NOT depend on stability after gnt_o.
REQ-012 A request with addr[1:0] != 0 SHALL still be granted, but:
- memory SHALL NOT be written (mem_we_o = 0);
- the response SHALL carry err_o = 1 and rdata_o = 0.
REQ-013 While halt_i = 1, no grant SHALL occur; a response already due from the previous cycle SHALL still be delivered.
REQ-014 The pointer-based priority SHALL be the FSM state LAST_IF / LAST_LS, updated only on a grant.
REQ-015 conflict_cnt_o SHALL increment on every cycle with if_req_i = ls_req_i = 1 and halt_i = 0, and SHALL saturate at all-ones.

Reset
REQ-016 While rst_i = 0, the block SHALL hold:
- all rvalid_o and err_o outputs at 0;
- all rdata_o outputs at 0;
- conflict_cnt_o at 0;
- the pointer at LAST_IF.
REQ-017 Grant and mem_* outputs SHALL be forced inactive while rst_i = 0 (gnt_o = 0, mem_we_o = 0).
REQ-018 Reset asserted mid-response SHALL drop rvalid_o immediately (asynchronous); no response SHALL be emitted after release for pre-reset grants.

Structure
REQ-019 `ADDR_WIDTH, `DATA_WIDTH and `ZERO SHALL come from the shared defines file; the pointer state encoding SHALL live in a shared package as a two-value enum.
REQ-020 One sub-module SHALL be used: rr_arb2, the combinational two-way round-robin selector (inputs req[1:0], ptr; output one-hot grant).

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Lone fetch: if_req=1 at 0x10, mem holds 0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle with 0xDEADBEEF, err=0.
- Conflict after reset: both requests, load at 0x20 -> ls_gnt first, if_gnt next cycle, conflict_cnt = 1.
- Sustained conflict, 4 cycles -> grants alternate LS, IF, LS, IF; conflict_cnt = 4.
- Store 0x12345678 to 0x40, then load 0x40 -> 0x12345678 returned one cycle after the load grant.
- Misaligned store to 0x41 -> gnt=1, mem_we_o=0, ls_rvalid with ls_err=1, memory at 0x40 unchanged.
- halt_i raised in a grant cycle+1 -> pending response still delivered, no further gnt until halt_i=0; rst_i pulsed low mid-response -> rvalid drops at once, counter = 0.
